// File: rtl/spike_imem_mc.sv
// Double-buffered input-spike memory for NUM_CORES SNN cores, written over Wishbone.
// A tick copies each enabled core's shadow bank into the active bank that drives its axons.
module spike_imem_mc #(
  parameter int          NUM_CORES   = 2,
  parameter int          NUM_AXONS   = 256,
  parameter logic [31:0] IMEM_BASE   = 32'h8000_0000,
  parameter logic [31:0] CORE_STRIDE = 32'h0001_0000,
  parameter bit          CLR_ON_TICK = 1'b1,
  parameter int          TS_WIDTH    = 16
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [31:0]                    wbs_dat_o,
  input  logic [NUM_CORES-1:0]           core_en_i,
  input  logic                           tick_i,
  output logic [NUM_CORES*NUM_AXONS-1:0] spike_axon_o,
  output logic                           swap_done_o,
  output logic [TS_WIDTH-1:0]            timestep_o
);

  localparam int W  = NUM_AXONS / 32;
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int WW = (W > 1) ? $clog2(W) : 1;

  logic [31:0]         r_shadow [NUM_CORES][W];
  logic [31:0]         r_active [NUM_CORES][W];
  logic                r_ack;
  logic [31:0]         r_datO;
  logic                r_swapDone;
  logic [TS_WIDTH-1:0] r_ts;

  logic [31:0]   w_off;
  logic [31:0]   w_core;
  logic [31:0]   w_idx;
  logic [31:0]   w_word;
  logic          w_isActive;
  logic          w_hit;
  logic          w_req;
  logic          w_wrEn;
  logic [CW-1:0] w_c;
  logic [WW-1:0] w_k;
  logic          w_unused;

  // Each core owns a window: W shadow words followed by W read-only active words.
  assign w_off      = wbs_adr_i - IMEM_BASE;
  assign w_core     = w_off / CORE_STRIDE;
  assign w_idx      = (w_off % CORE_STRIDE) >> 2;
  assign w_isActive = (w_idx >= 32'(W));
  assign w_word     = w_isActive ? (w_idx - 32'(W)) : w_idx;
  assign w_hit      = (wbs_adr_i >= IMEM_BASE) && (w_core < 32'(NUM_CORES)) &&
                      (w_idx < 32'(2 * W));
  assign w_c        = w_core[CW-1:0];
  assign w_k        = w_word[WW-1:0];
  assign w_req      = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
  assign w_wrEn     = w_req & wbs_we_i & ~w_isActive & core_en_i[w_c];
  assign w_unused   = ^{w_core[31:CW], w_word[31:WW]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        for (int k = 0; k < W; k++) begin
          r_shadow[c][k] <= '0;
          r_active[c][k] <= '0;
        end
      end
      r_ack      <= 1'b0;
      r_datO     <= '0;
      r_swapDone <= 1'b0;
      r_ts       <= '0;
    end else begin
      r_ack      <= w_req;
      r_swapDone <= tick_i;
      if (tick_i) begin
        r_ts <= r_ts + {{(TS_WIDTH-1){1'b0}}, 1'b1};
        for (int c = 0; c < NUM_CORES; c++) begin
          if (core_en_i[c]) begin
            for (int k = 0; k < W; k++) begin
              r_active[c][k] <= r_shadow[c][k];
              if (CLR_ON_TICK) r_shadow[c][k] <= '0;
            end
          end
        end
      end
      // Placed after the tick clear so a same-edge write survives into the next timestep.
      if (w_wrEn) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) r_shadow[w_c][w_k][8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
      if (w_req && !wbs_we_i) begin
        r_datO <= w_isActive ? r_active[w_c][w_k] : r_shadow[w_c][w_k];
      end
    end
  end

  // Active word 0 sits at the top of each core's slice.
  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    for (genvar k = 0; k < W; k++) begin : g_word
      assign spike_axon_o[c*NUM_AXONS + NUM_AXONS - 1 - 32*k -: 32] = r_active[c][k];
    end
  end

  assign wbs_ack_o   = r_ack;
  assign wbs_dat_o   = r_datO;
  assign swap_done_o = r_swapDone;
  assign timestep_o  = r_ts;

endmodule
